// File: rtl/board_link.sv
// Inter-board serial link: serializes processor words onto serial_tx and
// deserializes parity-checked frames from serial_rx into interrupt pulses.
module board_link #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd,
    input  logic [31:0] interface_data,
    output logic        tx_busy,
    output logic        serial_tx,
    input  logic        serial_rx,
    output logic        interrupt_eth,
    output logic [31:0] interrupt_source_data,
    output logic        rx_frame_err
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START_CHK,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    tx_state_t      tx_state;
    logic [CW-1:0]  tx_cnt;
    logic [4:0]     tx_bit;
    logic [31:0]    tx_shift;
    logic           tx_parity;

    rx_state_t      rx_state;
    logic [CW-1:0]  rx_cnt;
    logic [4:0]     rx_bit;
    logic [31:0]    rx_shift;
    logic           rx_par;
    logic           rx_meta;
    logic           rx_sync;

    // serial_tx is driven one bit ahead so each bit lands exactly on its period boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            tx_parity <= 1'b0;
            tx_busy   <= 1'b0;
            serial_tx <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (snd) begin
                        tx_shift  <= interface_data;
                        tx_parity <= ^interface_data;
                        tx_cnt    <= '0;
                        tx_bit    <= '0;
                        tx_busy   <= 1'b1;
                        serial_tx <= 1'b0;
                        tx_state  <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt    <= '0;
                        serial_tx <= tx_shift[0];
                        tx_state  <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 5'd31) begin
                            serial_tx <= tx_parity;
                            tx_state  <= TX_PARITY;
                        end else begin
                            tx_bit    <= tx_bit + 5'd1;
                            tx_shift  <= {1'b0, tx_shift[31:1]};
                            serial_tx <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TX_PARITY: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt    <= '0;
                        serial_tx <= 1'b1;
                        tx_state  <= TX_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_busy  <= 1'b0;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                default: begin
                    tx_state  <= TX_IDLE;
                    tx_busy   <= 1'b0;
                    serial_tx <= 1'b1;
                end
            endcase
        end
    end

    // Synchronizer resets to the idle-high level so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= serial_rx;
            rx_sync <= rx_meta;
        end
    end

    // START_CHK lands half a bit into the start bit, so later samples fall mid-bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state              <= RX_IDLE;
            rx_cnt                <= '0;
            rx_bit                <= '0;
            rx_shift              <= '0;
            rx_par                <= 1'b0;
            interrupt_eth         <= 1'b0;
            interrupt_source_data <= '0;
            rx_frame_err          <= 1'b0;
        end else begin
            interrupt_eth <= 1'b0;
            rx_frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (!rx_sync) begin
                        rx_state <= RX_START_CHK;
                    end
                end
                RX_START_CHK: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[31:1]};
                        if (rx_bit == 5'd31) begin
                            rx_state <= RX_PARITY;
                        end else begin
                            rx_bit <= rx_bit + 5'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_PARITY: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_par   <= rx_sync;
                        rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        if (rx_sync) begin
                            if ((^rx_shift) == rx_par) begin
                                interrupt_source_data <= rx_shift;
                                interrupt_eth         <= 1'b1;
                            end else begin
                                rx_frame_err <= 1'b1;
                            end
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                            rx_state     <= RX_WAIT_HIGH;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_WAIT_HIGH: begin
                    rx_cnt <= '0;
                    if (rx_sync) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: begin
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_link.sv
// Scoreboarded bench for board_link: loopback and bench-driven frames against
// a frame-level model of acceptance, busy time and received words.
module tb_board_link;

    localparam int N     = 16;
    localparam int FRAME = 35 * N;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snd = 1'b0;
    logic [31:0] interface_data = '0;
    logic        tx_busy;
    logic        serial_tx;
    logic        serial_rx;
    logic        interrupt_eth;
    logic [31:0] interrupt_source_data;
    logic        rx_frame_err;

    logic loop_en = 1'b1;
    logic rx_drv  = 1'b1;
    assign serial_rx = loop_en ? serial_tx : rx_drv;

    typedef struct {
        logic [31:0] data;
        int          acc;
        bit          timed;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        popped;
    int          tests = 0;
    int          failures = 0;
    int          cyc = 0;
    int          model_start = 0;
    int          model_free = 0;
    int          prev_free = 0;
    logic [31:0] model_last = '0;
    int          err_seen = 0;
    int          err_exp = 0;
    logic [31:0] w;
    bit          bad;

    board_link #(.CLKS_PER_BIT(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .snd(snd),
        .interface_data(interface_data),
        .tx_busy(tx_busy),
        .serial_tx(serial_tx),
        .serial_rx(serial_rx),
        .interrupt_eth(interrupt_eth),
        .interrupt_source_data(interrupt_source_data),
        .rx_frame_err(rx_frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe snd for one cycle; the model accepts only if its frame timer has expired
    task automatic applyStimulus(input logic [31:0] word);
        int e;
        snd = 1'b1;
        interface_data = word;
        e = cyc + 1;
        if (e >= model_free) begin
            exp_q.push_back('{word, e, loop_en});
            prev_free   = model_free;
            model_start = e;
            model_free  = e + FRAME;
        end
        tick();
        snd = 1'b0;
    endtask

    task automatic driveFrame(input logic [31:0] word, input bit bad_parity);
        logic [34:0] frame;
        frame[0]    = 1'b0;
        frame[32:1] = word;
        frame[33]   = (($countones(word) % 2) == 1) ^ bad_parity;
        frame[34]   = 1'b1;
        if (!bad_parity) exp_q.push_back('{word, 0, 1'b0});
        for (int i = 0; i < 35; i++) begin
            rx_drv = frame[i];
            repeat (N) tick();
        end
        rx_drv = 1'b1;
        repeat (2 * N) tick();
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || tx_busy) && n < 3000) begin
            tick();
            n++;
        end
        tests++;
        if (n >= 3000) begin
            failures++;
            $display("[TB] FAIL %s_timeout: %0d interrupts still pending, required 0", name, exp_q.size());
        end
        repeat (3 * N) tick();
    endtask

    task automatic waitIdle();
        int n = 0;
        while (tx_busy && n < 2 * FRAME) begin
            tick();
            n++;
        end
    endtask

    task automatic applyReset(input int n);
        rst_n = 1'b0;
        exp_q.delete();
        model_last  = '0;
        prev_free   = 0;
        model_start = 0;
        model_free  = 0;
        #1;
        checkOutput("rst_serial_tx", serial_tx, 1);
        checkOutput("rst_tx_busy", tx_busy, 0);
        checkOutput("rst_data", interrupt_source_data, 0);
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard on each interrupt and tracks busy/held data every cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (interrupt_eth) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    failures++;
                    $display("[TB] FAIL unexpected_irq: got interrupt with %h, required none", interrupt_source_data);
                end else begin
                    popped = exp_q.pop_front();
                    checkOutput("irq_data", interrupt_source_data, popped.data);
                    if (popped.timed) begin
                        tests++;
                        if (cyc - popped.acc < 540 || cyc - popped.acc > 566) begin
                            failures++;
                            $display("[TB] FAIL irq_latency: got %0d cycles, required 540..566", cyc - popped.acc);
                        end
                    end
                    model_last = popped.data;
                end
            end
            if (rx_frame_err) err_seen++;
            checkOutput("tx_busy", tx_busy,
                        ((cyc < prev_free) || (cyc >= model_start && cyc < model_free)) ? 1 : 0);
            checkOutput("held_data", interrupt_source_data, model_last);
        end
    end

    initial begin
        repeat (3) tick();
        checkOutput("reset_serial_tx", serial_tx, 1);
        checkOutput("reset_tx_busy", tx_busy, 0);
        checkOutput("reset_irq", interrupt_eth, 0);
        checkOutput("reset_data", interrupt_source_data, 0);
        checkOutput("reset_err", rx_frame_err, 0);
        rst_n = 1'b1;
        repeat (5) tick();

        applyStimulus(32'hDEADBEEF);
        waitDrain("t1");
        checkOutput("t1_data", interrupt_source_data, 32'hDEADBEEF);
        checkOutput("t1_errs", err_seen, err_exp);

        applyStimulus(32'h00000001);
        waitIdle();
        applyStimulus(32'h12345678);
        waitDrain("t2");
        checkOutput("t2_data", interrupt_source_data, 32'h12345678);

        applyStimulus(32'hAAAAAAAA);
        repeat (99) tick();
        applyStimulus(32'h55555555);
        waitDrain("t3");
        checkOutput("t3_data", interrupt_source_data, 32'hAAAAAAAA);

        loop_en = 1'b0;
        repeat (4) tick();
        driveFrame(32'h0000000F, 1'b1);
        err_exp++;
        checkOutput("t4_bad_errs", err_seen, err_exp);
        checkOutput("t4_hold", interrupt_source_data, 32'hAAAAAAAA);
        driveFrame(32'h0000000F, 1'b0);
        waitDrain("t4");
        checkOutput("t4_data", interrupt_source_data, 32'h0000000F);

        rx_drv = 1'b0;
        repeat (4) tick();
        rx_drv = 1'b1;
        repeat (3 * N) tick();
        checkOutput("t5_glitch_errs", err_seen, err_exp);
        rx_drv = 1'b0;
        repeat (40 * N) tick();
        err_exp++;
        checkOutput("t5_break_errs", err_seen, err_exp);
        rx_drv = 1'b1;
        repeat (2 * N) tick();
        driveFrame(32'h600DF00D, 1'b0);
        waitDrain("t5");
        checkOutput("t5_data", interrupt_source_data, 32'h600DF00D);
        checkOutput("t5_errs", err_seen, err_exp);

        loop_en = 1'b1;
        repeat (4) tick();
        applyStimulus(32'hCAFEF00D);
        repeat (199) tick();
        applyReset(3);
        repeat (FRAME + 50) tick();
        checkOutput("t6_data_zero", interrupt_source_data, 0);
        applyStimulus(32'hCAFEF00D);
        waitDrain("t6");
        checkOutput("t6_data", interrupt_source_data, 32'hCAFEF00D);

        for (int i = 0; i < 6; i++) begin
            w = $urandom;
            applyStimulus(w);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 500)) tick();
                applyStimulus($urandom);
            end
            waitDrain("rand_loop");
            checkOutput("rand_loop_data", interrupt_source_data, w);
        end

        loop_en = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            w   = $urandom;
            bad = ($urandom_range(0, 1) == 1);
            driveFrame(w, bad);
            if (bad) err_exp++;
            waitDrain("rand_rx");
        end
        checkOutput("rand_rx_errs", err_seen, err_exp);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/board_link.md
Name: board_link

Overview:
Inter-board serial link peripheral on the far side of the processor's send/interrupt interface. It accepts a 32-bit word that the processor sends with snd/interface_data and serializes it onto a single wire to the opponent board. It also deserializes frames arriving from the opponent and presents each valid word to the processor as interrupt_eth plus interrupt_source_data.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal values are even and >= 4.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
snd  input  1  processor send strobe, one cycle, qualifies interface_data
interface_data  input  32  word to transmit
tx_busy  output  1  transmitter not idle; snd is ignored while high
serial_tx  output  1  outgoing serial line, idles high
serial_rx  input  1  incoming serial line, asynchronous to clk
interrupt_eth  output  1  one-cycle pulse per valid received frame
interrupt_source_data  output  32  last valid received word
rx_frame_err  output  1  one-cycle pulse per rejected frame

Behaviour:
- Clocking and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: serial_tx=1, tx_busy=0, interrupt_eth=0, interrupt_source_data=0, rx_frame_err=0, both FSMs in IDLE, all counters 0.
- Frame format, 35 bits, each held CLKS_PER_BIT cycles:
  - start bit = 0
  - data bits [0..31], LSB first
  - even parity bit = XOR of the 32 data bits
  - stop bit = 1
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - In IDLE, snd=1 at a clock edge latches interface_data into the shift register and moves to START.
  - tx_busy and serial_tx=0 take effect in the cycle after acceptance.
  - Bit counter 0..31 in DATA; cycle counter 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - After STOP completes, TX returns to IDLE and tx_busy drops. snd in that same IDLE cycle is accepted, giving back-to-back frames with no idle gap.
  - snd while tx_busy=1 is dropped silently and the in-flight frame is unaffected.
  - Total busy time per frame = 35*CLKS_PER_BIT cycles.
- RX path: serial_rx passes through a 2-flop synchronizer; all RX logic uses the synchronized value.
- RX FSM states: IDLE, START_CHK, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: a synced low moves to START_CHK.
  - START_CHK: after CLKS_PER_BIT/2 cycles, resample. If high, treat as a glitch and return to IDLE with no error pulse. If low, go to DATA.
  - DATA/PARITY/STOP: sample once every CLKS_PER_BIT cycles (mid-bit) and shift data LSB first.
  - At the stop sample with stop=1 and parity correct: interrupt_source_data <= word and interrupt_eth=1 for exactly one cycle, then return to IDLE.
  - Parity wrong with stop=1: rx_frame_err pulses one cycle, interrupt_source_data is unchanged, return to IDLE.
  - Stop=0 (break or framing error): rx_frame_err pulses one cycle, then WAIT_HIGH until the synced line is 1, then IDLE.
- interrupt_source_data holds its value between frames. It is never partially updated.
- TX and RX are fully independent, so simultaneous transmit and receive is legal, including loopback.
- Reset asserted mid-frame: both FSMs and all outputs return to reset values immediately. serial_tx returns high, so the far end sees a stop/framing error. No interrupt_eth is produced for a partial frame.

Test Plan:
1. Loopback (serial_rx=serial_tx), CLKS_PER_BIT=16, snd with 0xDEADBEEF -> tx_busy high for 560 cycles; exactly one interrupt_eth pulse 540..566 cycles after the snd edge; interrupt_source_data=0xDEADBEEF; rx_frame_err never asserts.
2. Loopback, snd 0x00000001 and then snd 0x12345678 in the first IDLE cycle after tx_busy falls -> two interrupt_eth pulses 560 cycles apart; data 0x00000001, then 0x12345678.
3. snd 0xAAAAAAAA followed by snd 0x55555555 100 cycles later while busy -> only one frame on the wire; one interrupt with 0xAAAAAAAA.
4. Bench drives serial_rx with 0x0000000F and parity bit =1 (wrong) -> rx_frame_err one-cycle pulse; no interrupt_eth; interrupt_source_data keeps its prior value. Then drive a correct frame 0x0000000F -> interrupt with 0x0000000F.
5. serial_rx low for 4 cycles only (glitch) -> no rx_frame_err, no interrupt. Then serial_rx low for 40*16 cycles -> one rx_frame_err; RX rearms only after the line returns high, and the next good frame is received.
6. Assert rst_n=0 for 3 cycles at cycle 200 of a loopback frame 0xCAFEF00D -> serial_tx=1 and tx_busy=0 immediately; no interrupt_eth ever; interrupt_source_data=0. A subsequent snd 0xCAFEF00D completes normally.
